// File: rtl/apb_uart_regif_if.sv
// ---------------------------------------------------------------------------
// apb_uart_regif_if
// APB3 bus bundle used between a bus master and the UART register block.
//   PSEL, PENABLE, PWRITE : transfer control (master -> slave)
//   PADDR, PWDATA         : address / write data (master -> slave)
//   PRDATA, PREADY,
//   PSLVERR               : read data and completion response (slave -> master)
// ---------------------------------------------------------------------------
interface apb_uart_regif_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int APB_DW     = 32
) ();
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [APB_DW-1:0]     PWDATA;
    logic [APB_DW-1:0]     PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_uart_regif.sv
// ---------------------------------------------------------------------------
// apb_uart_regif
// APB register interface of a UART: pushes/pops the external TX/RX FIFOs,
// holds the line configuration and collects interrupt causes.
//   PCLK, PRESET     : clock, synchronous active-high reset
//   apb (slave)      : APB3 bus (zero wait except the RXDATA pop)
//   tx_data/tx_wr_en : TX FIFO push; tx_full, tx_level FIFO state
//   rx_data/rx_rd_en : RX FIFO pop (data valid the cycle after the pop);
//                      rx_empty, rx_level FIFO state
//   tx/rx_fifo_rst   : one-cycle FIFO flush pulses
//   *_error          : single-cycle receive error events
//   tx_en .. baud_div: line configuration outputs
//   irq              : registered interrupt request
// ---------------------------------------------------------------------------
module apb_uart_regif #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int APB_DW     = 32,
    parameter int ADDR_WIDTH = 32,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    apb_uart_regif_if.slave       apb,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_wr_en,
    input  logic                  tx_full,
    input  logic [LVL_W-1:0]      tx_level,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_rd_en,
    input  logic                  rx_empty,
    input  logic [LVL_W-1:0]      rx_level,
    output logic                  tx_fifo_rst,
    output logic                  rx_fifo_rst,
    input  logic                  parity_error,
    input  logic                  frame_error,
    input  logic                  overrun_error,
    output logic                  tx_en,
    output logic                  rx_en,
    output logic                  par_en,
    output logic                  par_type,
    output logic                  loopback,
    output logic [7:0]            prescale,
    output logic [15:0]           baud_div,
    output logic                  irq
);
    localparam logic [5:0] A_TXDATA  = 6'h00;
    localparam logic [5:0] A_RXDATA  = 6'h04;
    localparam logic [5:0] A_STATUS  = 6'h08;
    localparam logic [5:0] A_CTRL    = 6'h0C;
    localparam logic [5:0] A_BAUD    = 6'h10;
    localparam logic [5:0] A_FIFOCTL = 6'h14;
    localparam logic [5:0] A_INTSTAT = 6'h18;
    localparam logic [5:0] A_INTEN   = 6'h1C;
    localparam logic [5:0] A_LEVELS  = 6'h20;

    typedef enum logic {IDLE, RX_WAIT} state_t;

    state_t      state_q, state_d;
    logic [4:0]  ctrl_q;
    logic [7:0]  prescale_q;
    logic [15:0] baud_q;
    logic [3:0]  rx_thresh_q, tx_thresh_q;
    logic [2:0]  sticky_q, sticky_d;     // {parity, frame, overrun}
    logic [4:0]  int_en_q;
    logic        irq_q;
    logic        tx_fifo_rst_q, rx_fifo_rst_q;

    logic        access, reg_wr, pready, pslverr;
    logic [5:0]  addr;
    logic [31:0] rd_word;
    logic [2:0]  events, clr;
    logic        tx_low, rx_high;
    logic [3:0]  status;
    logic [4:0]  int_status;
    logic        unused_bits;

    assign access = apb.PSEL & apb.PENABLE;
    assign addr   = apb.PADDR[5:0];
    assign unused_bits = ^{apb.PADDR[ADDR_WIDTH-1:6], apb.PWDATA[APB_DW-1:20]};

    // Live interrupt causes; thresholds compared in a common wide domain so
    // small FIFO depths do not truncate the 4-bit thresholds.
    assign tx_low  = 16'(tx_level) <= 16'(tx_thresh_q);
    assign rx_high = (rx_thresh_q != 4'd0) && (16'(rx_level) >= 16'(rx_thresh_q));
    assign status  = {rx_level == LVL_W'(FIFO_DEPTH), rx_level == '0,
                      tx_level == LVL_W'(FIFO_DEPTH), tx_level == '0};
    assign int_status = {sticky_q, rx_high, tx_low};

    always_comb begin
        state_d  = state_q;
        pready   = 1'b1;
        pslverr  = 1'b0;
        rd_word  = '0;
        tx_wr_en = 1'b0;
        rx_rd_en = 1'b0;
        reg_wr   = 1'b0;
        if (!PRESET) begin
            case (state_q)
                IDLE: if (access) begin
                    case (addr)
                        A_TXDATA:  if (apb.PWRITE && !tx_full) tx_wr_en = 1'b1;
                                   else pslverr = 1'b1;
                        A_RXDATA:  if (!apb.PWRITE && !rx_empty) begin
                                       rx_rd_en = 1'b1;
                                       pready   = 1'b0;
                                       state_d  = RX_WAIT;
                                   end else pslverr = 1'b1;
                        A_STATUS:  if (apb.PWRITE) pslverr = 1'b1;
                                   else rd_word = 32'(status);
                        A_CTRL:    if (apb.PWRITE) reg_wr = 1'b1;
                                   else rd_word = {16'd0, prescale_q, 3'd0, ctrl_q};
                        A_BAUD:    if (apb.PWRITE) reg_wr = 1'b1;
                                   else rd_word = {16'd0, baud_q};
                        A_FIFOCTL: if (apb.PWRITE) reg_wr = 1'b1;
                                   else rd_word = {12'd0, tx_thresh_q, 4'd0, rx_thresh_q, 8'd0};
                        A_INTSTAT: if (apb.PWRITE) reg_wr = 1'b1;
                                   else rd_word = 32'(int_status);
                        A_INTEN:   if (apb.PWRITE) reg_wr = 1'b1;
                                   else rd_word = 32'(int_en_q);
                        A_LEVELS:  if (apb.PWRITE) pslverr = 1'b1;
                                   else rd_word = (32'(rx_level) << 16) | 32'(tx_level);
                        default:   pslverr = 1'b1;
                    endcase
                end
                RX_WAIT: begin
                    // Popped word is returned now; if the master abandoned
                    // the transfer it is simply dropped.
                    state_d = IDLE;
                    if (access) rd_word = 32'(rx_data);
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign events = {parity_error, frame_error, overrun_error};
    assign clr    = (reg_wr && addr == A_INTSTAT) ? apb.PWDATA[4:2] : 3'd0;

    // A new event wins over a coincident write-1-to-clear.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sticky
            assign sticky_d[gi] = events[gi] | (sticky_q[gi] & ~clr[gi]);
        end
    endgenerate

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= IDLE;
            ctrl_q        <= '0;
            prescale_q    <= '0;
            baud_q        <= '0;
            rx_thresh_q   <= '0;
            tx_thresh_q   <= '0;
            sticky_q      <= '0;
            int_en_q      <= '0;
            irq_q         <= 1'b0;
            tx_fifo_rst_q <= 1'b0;
            rx_fifo_rst_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sticky_q      <= sticky_d;
            irq_q         <= |(int_status & int_en_q);
            tx_fifo_rst_q <= reg_wr && (addr == A_FIFOCTL) && apb.PWDATA[0];
            rx_fifo_rst_q <= reg_wr && (addr == A_FIFOCTL) && apb.PWDATA[1];
            if (reg_wr) begin
                case (addr)
                    A_CTRL: begin
                        ctrl_q     <= apb.PWDATA[4:0];
                        prescale_q <= apb.PWDATA[15:8];
                    end
                    A_BAUD:    baud_q <= apb.PWDATA[15:0];
                    A_FIFOCTL: begin
                        rx_thresh_q <= apb.PWDATA[11:8];
                        tx_thresh_q <= apb.PWDATA[19:16];
                    end
                    A_INTEN:   int_en_q <= apb.PWDATA[4:0];
                    default: ;
                endcase
            end
        end
    end

    assign apb.PREADY  = pready;
    assign apb.PSLVERR = pslverr;
    assign apb.PRDATA  = (pready && !pslverr) ? APB_DW'(rd_word) : '0;

    assign tx_data     = apb.PWDATA[DATA_WIDTH-1:0];
    assign tx_fifo_rst = tx_fifo_rst_q;
    assign rx_fifo_rst = rx_fifo_rst_q;
    assign {loopback, par_type, par_en, rx_en, tx_en} = ctrl_q;
    assign prescale    = prescale_q;
    assign baud_div    = baud_q;
    assign irq         = irq_q;
endmodule

// File: tb/tb_apb_uart_regif.sv
module tb_apb_uart_regif;
    localparam int LVL_W = 5;

    logic PCLK = 1'b0;
    logic PRESET;
    always #5 PCLK = ~PCLK;

    apb_uart_regif_if #(.ADDR_WIDTH(32), .APB_DW(32)) apb ();

    logic [7:0]       tx_data, rx_data;
    logic             tx_wr_en, rx_rd_en, tx_full, rx_empty;
    logic [LVL_W-1:0] tx_level, rx_level;
    logic             tx_fifo_rst, rx_fifo_rst;
    logic             parity_error, frame_error, overrun_error;
    logic             tx_en, rx_en, par_en, par_type, loopback, irq;
    logic [7:0]       prescale;
    logic [15:0]      baud_div;

    apb_uart_regif dut (
        .PCLK(PCLK), .PRESET(PRESET), .apb(apb),
        .tx_data(tx_data), .tx_wr_en(tx_wr_en), .tx_full(tx_full), .tx_level(tx_level),
        .rx_data(rx_data), .rx_rd_en(rx_rd_en), .rx_empty(rx_empty), .rx_level(rx_level),
        .tx_fifo_rst(tx_fifo_rst), .rx_fifo_rst(rx_fifo_rst),
        .parity_error(parity_error), .frame_error(frame_error), .overrun_error(overrun_error),
        .tx_en(tx_en), .rx_en(rx_en), .par_en(par_en), .par_type(par_type), .loopback(loopback),
        .prescale(prescale), .baud_div(baud_div), .irq(irq)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_bad = 0;
    int tx_cnt = 0, pop_cnt = 0, tf_cnt = 0, rf_cnt = 0;
    logic [7:0] last_tx = 8'h00;
    logic [7:0] rx_next = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compares every completed APB transfer against the queue and
    // tallies the side-band strobes. The RX FIFO model presents the popped
    // word during the cycle that follows the pop strobe.
    always @(negedge PCLK) begin
        if (PRESET === 1'b0 && apb.PSEL && apb.PENABLE && apb.PREADY) begin
            if (sb_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL sb_unexpected: transfer at addr 0x%02h with nothing expected", apb.PADDR[7:0]);
            end else begin
                mon_e = sb_q.pop_front();
                $display("txn %-12s addr=0x%02h wr=%0d prdata=0x%08h slverr=%0d",
                         mon_e.name, apb.PADDR[7:0], apb.PWRITE, apb.PRDATA, apb.PSLVERR);
                chk({mon_e.name, "_rdata"}, apb.PRDATA, mon_e.rdata);
                chk({mon_e.name, "_slverr"}, 32'(apb.PSLVERR), 32'(mon_e.err));
            end
        end
        if (tx_wr_en) begin tx_cnt++; last_tx = tx_data; end
        if (rx_rd_en) begin pop_cnt++; rx_data = rx_next; end
        if (tx_fifo_rst) tf_cnt++;
        if (rx_fifo_rst) rf_cnt++;
    end

    // ---------------- reference model ----------------
    logic [31:0] ctrl_m;
    logic [15:0] baud_m;
    logic [3:0]  rx_thr_m, tx_thr_m;
    logic [2:0]  sticky_m;      // {parity, frame, overrun}
    logic [4:0]  int_en_m;

    task automatic model_reset();
        ctrl_m = 0; baud_m = 0; rx_thr_m = 0; tx_thr_m = 0; sticky_m = 0; int_en_m = 0;
    endtask

    function automatic logic [4:0] m_int_status();
        logic txlow, rxhigh;
        txlow  = int'(tx_level) <= int'(tx_thr_m);
        rxhigh = (rx_thr_m != 0) && (int'(rx_level) >= int'(rx_thr_m));
        return {sticky_m, rxhigh, txlow};
    endfunction

    function automatic logic m_err(input logic [5:0] a, input logic wr);
        case (a)
            6'h00: return wr ? tx_full : 1'b1;
            6'h04: return wr ? 1'b1 : rx_empty;
            6'h08, 6'h20: return wr;
            6'h0C, 6'h10, 6'h14, 6'h18, 6'h1C: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [5:0] a);
        case (a)
            6'h04: return {24'd0, rx_next};
            6'h08: return {28'd0, rx_level == 16, rx_level == 0, tx_level == 16, tx_level == 0};
            6'h0C: return ctrl_m;
            6'h10: return {16'd0, baud_m};
            6'h14: return {12'd0, tx_thr_m, 4'd0, rx_thr_m, 8'd0};
            6'h18: return {27'd0, m_int_status()};
            6'h1C: return {27'd0, int_en_m};
            6'h20: return {11'd0, rx_level, 11'd0, tx_level};
            default: return 32'd0;
        endcase
    endfunction

    task automatic set_levels(input int tl, input int rl);
        tx_level = LVL_W'(tl); tx_full = (tl == 16);
        rx_level = LVL_W'(rl); rx_empty = (rl == 0);
    endtask

    // One complete APB transfer. ev[4:2] = {parity, frame, overrun} pulses
    // driven during the access phase.
    task automatic apb_xfer(input string name, input logic [5:0] a, input logic wr,
                            input logic [31:0] wd, input logic [4:0] ev);
        exp_t e;
        int waits, exp_waits, tx0, pop0, tf0, rf0;
        logic err;
        err = m_err(a, wr);
        e.err = err; e.name = name;
        e.rdata = (!wr && !err) ? m_read(a) : 32'd0;
        exp_waits = (a == 6'h04 && !wr && !err) ? 1 : 0;
        sb_q.push_back(e);
        tx0 = tx_cnt; pop0 = pop_cnt; tf0 = tf_cnt; rf0 = rf_cnt;

        @(posedge PCLK); #1;
        apb.PSEL = 1; apb.PENABLE = 0; apb.PWRITE = wr; apb.PADDR = {26'd0, a}; apb.PWDATA = wd;
        @(posedge PCLK); #1;
        apb.PENABLE = 1;
        {parity_error, frame_error, overrun_error} = ev[4:2];
        waits = 0;
        forever begin
            @(negedge PCLK);
            if (apb.PREADY) break;
            waits++;
            if (waits > 4) begin
                n_cmp++; n_bad++;
                $display("FAIL %s_timeout: PREADY low for %0d cycles, expected completion", name, waits);
                if (sb_q.size() > 0) void'(sb_q.pop_back());
                break;
            end
        end
        @(posedge PCLK); #1;
        apb.PSEL = 0; apb.PENABLE = 0;
        {parity_error, frame_error, overrun_error} = 3'b000;

        // Model update for the completed transfer.
        if (!err && wr) begin
            case (a)
                6'h0C: ctrl_m = wd & 32'h0000_FF1F;
                6'h10: baud_m = wd[15:0];
                6'h14: begin rx_thr_m = wd[11:8]; tx_thr_m = wd[19:16]; end
                6'h18: sticky_m = sticky_m & ~wd[4:2];
                6'h1C: int_en_m = wd[4:0];
                default: ;
            endcase
        end
        sticky_m = sticky_m | ev[4:2];

        chk({name, "_waits"}, 32'(waits), 32'(exp_waits));
        chk({name, "_txpush"}, 32'(tx_cnt - tx0), (a == 6'h00 && wr && !err) ? 32'd1 : 32'd0);
        if (a == 6'h00 && wr && !err) chk({name, "_txdata"}, 32'(last_tx), 32'(wd[7:0]));
        chk({name, "_rxpop"}, 32'(pop_cnt - pop0), 32'(exp_waits));
        repeat (3) @(posedge PCLK);
        #1;
        chk({name, "_txflush"}, 32'(tf_cnt - tf0), (a == 6'h14 && wr) ? 32'(wd[0]) : 32'd0);
        chk({name, "_rxflush"}, 32'(rf_cnt - rf0), (a == 6'h14 && wr) ? 32'(wd[1]) : 32'd0);
        chk({name, "_cfg"}, {loopback, par_type, par_en, rx_en, tx_en, prescale, baud_div},
            {ctrl_m[4:0], ctrl_m[15:8], baud_m});
        chk({name, "_irq"}, 32'(irq), 32'(|(m_int_status() & int_en_m)));
    endtask

    task automatic pulse_ev(input logic [2:0] ev);
        @(posedge PCLK); #1;
        {parity_error, frame_error, overrun_error} = ev;
        @(posedge PCLK); #1;
        {parity_error, frame_error, overrun_error} = 3'b000;
        sticky_m = sticky_m | ev;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int p0;
        logic [5:0] a;
        logic wr;
        logic [4:0] ev;
        PRESET = 1;
        apb.PSEL = 0; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = 0; apb.PWDATA = 0;
        parity_error = 0; frame_error = 0; overrun_error = 0;
        rx_data = 8'hEE;
        set_levels(0, 0);
        model_reset();
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_pready", 32'(apb.PREADY), 32'd1);
        chk("rst_slverr", 32'(apb.PSLVERR), 32'd0);
        chk("rst_prdata", apb.PRDATA, 32'd0);
        chk("rst_outs", {irq, tx_wr_en, rx_rd_en, tx_fifo_rst, rx_fifo_rst, tx_en, rx_en,
                         par_en, par_type, loopback, prescale, baud_div}, 32'd0);
        @(posedge PCLK); #1;
        PRESET = 0;

        // TX push and full rejection
        set_levels(3, 0);
        apb_xfer("tx_push", 6'h00, 1, 32'h0000_005A, 0);
        set_levels(16, 0);
        apb_xfer("tx_full", 6'h00, 1, 32'h0000_005A, 0);
        apb_xfer("tx_read", 6'h00, 0, 32'h0, 0);

        // RX pop with one wait state, and empty rejection
        set_levels(2, 4);
        rx_next = 8'hA5;
        apb_xfer("rx_pop", 6'h04, 0, 32'h0, 0);
        apb_xfer("rx_write", 6'h04, 1, 32'h0, 0);
        set_levels(2, 0);
        apb_xfer("rx_empty", 6'h04, 0, 32'h0, 0);

        // Configuration registers
        apb_xfer("ctrl_wr", 6'h0C, 1, 32'h0000_331F, 0);
        apb_xfer("baud_wr", 6'h10, 1, 32'h0000_1234, 0);
        apb_xfer("ctrl_rd", 6'h0C, 0, 32'h0, 0);
        apb_xfer("baud_rd", 6'h10, 0, 32'h0, 0);

        // Sticky interrupt, W1C, clear coincident with event
        apb_xfer("inten_wr", 6'h1C, 1, 32'h0000_001C, 0);
        pulse_ev(3'b100);
        apb_xfer("ist_par", 6'h18, 0, 32'h0, 0);
        apb_xfer("ist_clr", 6'h18, 1, 32'h0000_0010, 0);
        apb_xfer("ist_clr_ev", 6'h18, 1, 32'h0000_0010, 5'b10000);
        apb_xfer("ist_kept", 6'h18, 0, 32'h0, 0);

        // FIFO control: flush pulses, thresholds, RXHIGH
        apb_xfer("fctl_wr", 6'h14, 1, 32'h0000_0303, 0);
        apb_xfer("fctl_rd", 6'h14, 0, 32'h0, 0);
        set_levels(5, 3);
        apb_xfer("ist_rxhi", 6'h18, 0, 32'h0, 0);
        apb_xfer("levels", 6'h20, 0, 32'h0, 0);
        apb_xfer("status", 6'h08, 0, 32'h0, 0);

        // Illegal accesses leave state untouched
        apb_xfer("undef_rd", 6'h24, 0, 32'h0, 0);
        apb_xfer("undef_wr", 6'h24, 1, 32'hFFFF_FFFF, 0);
        apb_xfer("status_wr", 6'h08, 1, 32'hFFFF_FFFF, 0);
        apb_xfer("ctrl_keep", 6'h0C, 0, 32'h0, 0);

        // Reset during the wait state of an RX pop
        set_levels(1, 2);
        rx_next = 8'h3C;
        p0 = pop_cnt;
        @(posedge PCLK); #1;
        apb.PSEL = 1; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = 32'h04;
        @(posedge PCLK); #1;
        apb.PENABLE = 1;
        @(negedge PCLK);
        chk("abort_wait", 32'(apb.PREADY), 32'd0);
        @(posedge PCLK); #1;
        PRESET = 1; apb.PSEL = 0; apb.PENABLE = 0;
        @(posedge PCLK); #1;
        PRESET = 0;
        model_reset();
        repeat (3) @(posedge PCLK);
        #1;
        chk("abort_pops", 32'(pop_cnt - p0), 32'd1);
        apb_xfer("post_rst_ctrl", 6'h0C, 0, 32'h0, 0);
        apb_xfer("post_rst_ist", 6'h18, 0, 32'h0, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 3) == 0)
                set_levels(int'($urandom_range(0, 16)), int'($urandom_range(0, 16)));
            if ($urandom_range(0, 5) == 0)
                pulse_ev(3'($urandom_range(1, 7)));
            a  = 6'($urandom_range(0, 11) * 4);
            wr = 1'($urandom_range(0, 1));
            if (a == 6'h04) rx_next = 8'($urandom);
            ev = (a != 6'h04 && $urandom_range(0, 3) == 0) ? {3'($urandom_range(0, 7)), 2'b00} : 5'd0;
            apb_xfer($sformatf("rnd%0d", i), a, wr, $urandom, ev);
        end

        if (sb_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_leftover: %0d pending, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
